// File: rtl/cpu_memory_pkg.sv
// cpu_memory_pkg: opcodes, stage-4 state encoding and opcode-class helpers
package cpu_memory_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLL  = 6'd5;
  localparam logic [5:0] OP_SRL  = 6'd6;
  localparam logic [5:0] OP_SRA  = 6'd7;
  localparam logic [5:0] OP_CLT  = 6'd8;
  localparam logic [5:0] OP_CLTU = 6'd9;
  localparam logic [5:0] OP_JMP  = 6'd10;
  localparam logic [5:0] OP_JMPR = 6'd11;
  localparam logic [5:0] OP_LD   = 6'd12;
  localparam logic [5:0] OP_LDB  = 6'd13;
  localparam logic [5:0] OP_LDBU = 6'd14;
  localparam logic [5:0] OP_LDH  = 6'd15;
  localparam logic [5:0] OP_LDHU = 6'd16;
  localparam logic [5:0] OP_LDW  = 6'd17;
  localparam logic [5:0] OP_BEQ  = 6'd18;
  localparam logic [5:0] OP_BNE  = 6'd19;
  localparam logic [5:0] OP_BLT  = 6'd20;
  localparam logic [5:0] OP_STB  = 6'd21;
  localparam logic [5:0] OP_STH  = 6'd22;
  localparam logic [5:0] OP_STW  = 6'd23;
  localparam logic [5:0] OP_CFG  = 6'd24;
  localparam logic [5:0] OP_RTE  = 6'd25;
  localparam logic [5:0] OP_SYS  = 6'd26;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {[OP_LDB:OP_LDW]};
  endfunction
  // every register-writing opcode sits at or below the last load
  function automatic logic writes_reg(input logic [5:0] op);
    return op <= OP_LDW;
  endfunction
endpackage

// File: rtl/cpu_memory_if.sv
// cpu_memory_if: execute-stage inputs, data-bus read return and register-file write port
interface cpu_memory_if;
  logic        stall_in;
  logic [5:0]  p3_op;
  logic [4:0]  p3_dest;
  logic [31:0] p3_alu_out;
  logic [1:0]  p3_addr_lsb;
  logic        p3_mem_read;
  logic        cpud_rvalid;
  logic [31:0] cpud_rdata;
  logic        mem_stall;
  logic        p4_write_en;
  logic [4:0]  p4_dest;
  logic [31:0] p4_wdata;
  logic        p4_bus_error;
  logic        p4_misaligned;
  modport slave (
    input  stall_in, p3_op, p3_dest, p3_alu_out, p3_addr_lsb, p3_mem_read, cpud_rvalid, cpud_rdata,
    output mem_stall, p4_write_en, p4_dest, p4_wdata, p4_bus_error, p4_misaligned
  );
  modport master (
    output stall_in, p3_op, p3_dest, p3_alu_out, p3_addr_lsb, p3_mem_read, cpud_rvalid, cpud_rdata,
    input  mem_stall, p4_write_en, p4_dest, p4_wdata, p4_bus_error, p4_misaligned
  );
endinterface

// File: rtl/cpu_memory_load_align.sv
// cpu_memory_load_align: selects the addressed byte/half of a load word and extends it
module cpu_memory_load_align
  import cpu_memory_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lsb,
  input  logic [31:0] src,
  output logic [31:0] word
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = src[{lsb, 3'b000} +: 8];
  assign h = src[{lsb[1], 4'b0000} +: 16];
  always_comb
    word = op == OP_LDB  ? {{24{b[7]}}, b} :
           op == OP_LDBU ? {24'd0, b} :
           op == OP_LDH  ? {{16{h[15]}}, h} :
           op == OP_LDHU ? {16'd0, h} : src;
endmodule

// File: rtl/cpu_memory.sv
// cpu_memory: pipeline stage 4, waits on load data, aligns it and drives the register-file write port
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clock,
  input logic         reset,
  cpu_memory_if.slave bus
);
  state_t      state, state_nx;
  logic        p4_valid, mem_read_q, err_q, stall, capture, timeout, retire, load_err;
  logic [5:0]  op_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_q, hold_q, src, load_word;
  logic [1:0]  lsb_q;
  logic [7:0]  wait_cnt;
  assign bus.mem_stall = state == WAIT && !bus.cpud_rvalid;
  assign stall    = bus.stall_in | bus.mem_stall;
  assign capture  = !stall;
  assign timeout  = bus.mem_stall && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign retire   = p4_valid && !stall;
  assign load_err = is_load(op_q) && !mem_read_q;
  // data that arrived under a downstream stall is replayed from hold_q
  assign src = state == DONE ? hold_q : bus.cpud_rdata;
  assign bus.p4_dest       = dest_q;
  assign bus.p4_wdata      = is_load(op_q) ? load_word : alu_q;
  assign bus.p4_write_en   = retire && writes_reg(op_q) && dest_q != 5'd0 && !err_q && !load_err;
  assign bus.p4_bus_error  = retire && err_q;
  assign bus.p4_misaligned = retire && load_err;
  cpu_memory_load_align u_align (
    .op  (op_q),
    .lsb (lsb_q),
    .src (src),
    .word(load_word)
  );
  always_comb
    state_nx = capture && bus.p3_mem_read ? WAIT :
               timeout ? IDLE :
               state == WAIT && bus.cpud_rvalid ? (bus.stall_in ? DONE : IDLE) :
               state == DONE && !bus.stall_in ? IDLE : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      p4_valid   <= 1'b0;
      wait_cnt   <= 8'd0;
      hold_q     <= 32'd0;
      err_q      <= 1'b0;
      op_q       <= OP_ADD;
      dest_q     <= 5'd0;
      alu_q      <= 32'd0;
      lsb_q      <= 2'd0;
      mem_read_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= capture && bus.p3_mem_read ? 8'd0 : bus.mem_stall ? wait_cnt + 8'd1 : wait_cnt;
      if (state == WAIT && bus.cpud_rvalid && bus.stall_in) hold_q <= bus.cpud_rdata;
      if (capture) begin
        p4_valid   <= 1'b1;
        op_q       <= bus.p3_op;
        dest_q     <= bus.p3_dest;
        alu_q      <= bus.p3_alu_out;
        lsb_q      <= bus.p3_addr_lsb;
        mem_read_q <= bus.p3_mem_read;
        err_q      <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule
